// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single FIFO write port between NUM_REQ
// requesters. A granted requester may write up to MAX_BURST words. Writing
// stalls while the FIFO is full. Priority rotates past the granted requester
// after every burst, and one idle cycle separates consecutive bursts.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous, active-high reset
//   req        - per-requester request (word ready on its data slice)
//   req_data   - packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full  - FIFO full flag
//   ack        - one-hot, combinational: requester's word written this cycle
//   grant      - one-hot registered grant, zero when idle
//   grant_id   - index of the granted requester, zero when idle
//   fifo_we    - FIFO write enable, combinational
//   fifo_wdata - granted requester's word, zero when idle
//   busy       - high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;

  logic               sel_found_s;
  logic [IDW-1:0]     sel_id_s;
  logic               busy_s;
  logic               req_g_s;
  logic               we_s;
  logic               last_s;
  logic [IDW-1:0]     rr_next_s;

  // Round-robin search: first set request starting at rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!sel_found_s && req[idx]) begin
        sel_found_s = 1'b1;
        sel_id_s    = IDW'(idx);
      end else begin
        sel_id_s    = sel_id_s;
      end
    end
  end

  // Write datapath: only the granted requester can reach the FIFO, and never
  // while the FIFO is full. Data follows the grant even during a stall.
  always_comb begin
    busy_s  = (state_q == BURST);
    req_g_s = req[grant_id_q];
    we_s    = busy_s & req_g_s & ~fifo_full;
    last_s  = (burst_cnt_q == CW'(MAX_BURST - 1));
    if (we_s) begin
      ack = grant_q;
    end else begin
      ack = '0;
    end
    if (busy_s) begin
      fifo_wdata = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      fifo_wdata = '0;
    end
  end

  // Priority pointer moves to the requester after the one just served.
  always_comb begin
    if (grant_id_q == IDW'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_id_q + IDW'(1);
    end
  end

  // Next-state logic of the IDLE/BURST controller.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d     = BURST;
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id_s;
          grant_id_d  = sel_id_s;
          burst_cnt_d = '0;
        end else begin
          state_d     = IDLE;
        end
      end
      BURST: begin
        // Release when the requester withdraws or its last word is written.
        // A full FIFO alone never releases the grant.
        if (!req_g_s || (we_s && last_s)) begin
          state_d     = IDLE;
          rr_ptr_d    = rr_next_s;
          grant_d     = '0;
          grant_id_d  = '0;
          burst_cnt_d = '0;
        end else if (we_s) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        rr_ptr_d    = '0;
        grant_d     = '0;
        grant_id_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // State registers; asynchronous reset abandons any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign fifo_we  = we_s;
  assign busy     = busy_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled a further
// time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        fifo_we;
  logic [7:0]  fifo_wdata;
  logic        busy;

  int passed;
  int failed;
  int total;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .ack       (ack),
    .grant     (grant),
    .grant_id  (grant_id),
    .fifo_we   (fifo_we),
    .fifo_wdata(fifo_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected vector.
  task automatic chk_outs(input string tag, input logic [3:0] g, input logic [1:0] gid,
                          input logic we, input logic [3:0] a, input logic [7:0] wd,
                          input logic b);
    #1;
    chk({tag, ".grant"},    32'(grant),      32'(g));
    chk({tag, ".grant_id"}, 32'(grant_id),   32'(gid));
    chk({tag, ".fifo_we"},  32'(fifo_we),    32'(we));
    chk({tag, ".ack"},      32'(ack),        32'(a));
    chk({tag, ".wdata"},    32'(fifo_wdata), 32'(wd));
    chk({tag, ".busy"},     32'(busy),       32'(b));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] gid;
    passed    = 0;
    failed    = 0;
    total     = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    req_data  = 32'h0000_0000;
    fifo_full = 1'b0;

    // 1: reset state and idle with no requests
    do_reset();
    chk_outs("t1_reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_outs("t1_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    end

    // 2: single requester 2, four writes, bubble, re-grant
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    req      = 4'b0100;
    chk_outs("t2_req_cycle", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_outs("t2_write", 4'b0100, 2'd2, 1'b1, 4'b0100, 8'hA5, 1'b1);
    end
    cyc();
    chk_outs("t2_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    chk_outs("t2_regrant", 4'b0100, 2'd2, 1'b1, 4'b0100, 8'hA5, 1'b1);
    do_reset();

    // 3: all requesting; bursts 0,1,2,3,0,1 with one bubble between bursts
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1111;
    for (int k = 0; k < 30; k++) begin
      if (k != 0) cyc();
      if ((k % 5) == 0) begin
        chk_outs("t3_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
      end else begin
        gid = 2'((k / 5) % 4);
        chk_outs("t3_burst", 4'b0001 << gid, gid, 1'b1, 4'b0001 << gid,
                 8'h10 + 8'(gid), 1'b1);
      end
    end
    do_reset();

    // 4: requester 1 stalled by FIFO full after two writes
    req_data = {8'h00, 8'h00, 8'h5C, 8'h00};
    req      = 4'b0010;
    chk_outs("t4_req_cycle", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_outs("t4_write_pre", 4'b0010, 2'd1, 1'b1, 4'b0010, 8'h5C, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      fifo_full = 1'b1;
      chk_outs("t4_stall", 4'b0010, 2'd1, 1'b0, 4'b0000, 8'h5C, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      fifo_full = 1'b0;
      chk_outs("t4_write_post", 4'b0010, 2'd1, 1'b1, 4'b0010, 8'h5C, 1'b1);
    end
    cyc();
    chk_outs("t4_release", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    do_reset();

    // 5: requester 3 withdraws after one write; pointer wraps to 0
    req_data = {8'hC3, 8'h00, 8'h22, 8'h01};
    req      = 4'b1000;
    chk_outs("t5_req_cycle", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    req = 4'b1011;
    chk_outs("t5_write", 4'b1000, 2'd3, 1'b1, 4'b1000, 8'hC3, 1'b1);
    cyc();
    req = 4'b0011;
    chk_outs("t5_withdraw", 4'b1000, 2'd3, 1'b0, 4'b0000, 8'hC3, 1'b1);
    cyc();
    chk_outs("t5_bubble", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    chk_outs("t5_next_grant", 4'b0001, 2'd0, 1'b1, 4'b0001, 8'h01, 1'b1);
    do_reset();

    // 6: asynchronous reset in the middle of requester 2's burst
    req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    req      = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_outs("t6_write", 4'b0100, 2'd2, 1'b1, 4'b0100, 8'h77, 1'b1);
    end
    cyc();
    rst = 1'b1;
    chk_outs("t6_async_rst", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    req      = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    cyc();
    rst = 1'b0;
    chk_outs("t6_post_rst_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
    cyc();
    chk_outs("t6_first_grant", 4'b0001, 2'd0, 1'b1, 4'b0001, 8'h11, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
